// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-unit bus bundling the ROM, decoder, branch and start/done signals
//
// Purpose: carries every non-clock/non-reset signal of instr_fetch.
//   master: the fetch unit (drives rom_addr, instruction, instr_ROM_ctr, instr_valid, done)
//   slave : its environment (drives start, stall, branch_taken, branch_target, rom_data)
// Signals:
//   start          1     pulse: begin execution at address 0
//   stall          1     hold current PC/instruction this cycle
//   branch_taken   1     taken branch/jump resolved for the current instruction
//   branch_target  PC_W  absolute branch target
//   rom_data       IW    combinational instruction ROM read data
//   rom_addr       PC_W  ROM address (= pc)
//   instruction    IW    word to decoder (rom_data while running, else 0)
//   instr_ROM_ctr  PC_W  index of the presented instruction (= pc)
//   instr_valid    1     high while running
//   done           1     high after the run ends, until next start or reset
interface instr_fetch_if #(
  parameter int PC_W = 12,
  parameter int IW   = 9
);
  logic            start;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [IW-1:0]   rom_data;
  logic [PC_W-1:0] rom_addr;
  logic [IW-1:0]   instruction;
  logic [PC_W-1:0] instr_ROM_ctr;
  logic            instr_valid;
  logic            done;

  modport master (
    input  start, stall, branch_taken, branch_target, rom_data,
    output rom_addr, instruction, instr_ROM_ctr, instr_valid, done
  );

  modport slave (
    output start, stall, branch_taken, branch_target, rom_data,
    input  rom_addr, instruction, instr_ROM_ctr, instr_valid, done
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter and fetch sequencer feeding the control decoder
//
// Purpose: walks the instruction ROM from address 0 after start, following taken
//   branches, until a halt word, an out-of-range branch or the last program word.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset (wins over everything)
//   bus          master side of instr_fetch_if (ROM, decoder, branch, start/done)
//   cycle_count  out  [15:0] RUN cycles since last start, saturating
//                     (present only when FETCH_CYCLE_CNT_EN is defined)
module instr_fetch #(
  parameter int              PC_W      = 12,
  parameter int              IW        = 9,
  parameter int              PROG_LEN  = 4096,
  parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FETCH_CYCLE_CNT_EN
  instr_fetch_if.master      bus,
  output logic [15:0]        cycle_count
`else
  instr_fetch_if.master      bus
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // One extra bit so PROG_LEN == 2**PC_W is representable in the compare.
  localparam logic [PC_W:0]   LEN_EXT = (PC_W+1)'(PROG_LEN);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            is_halt;
  logic            target_ok;

  assign is_halt   = (bus.rom_data == HALT_WORD);
  assign target_ok = ({1'b0, bus.branch_target} < LEN_EXT);

  assign bus.rom_addr      = pc;
  assign bus.instr_ROM_ctr = pc;
  // ROM is combinational, so the word follows pc within the same cycle.
  assign bus.instruction   = (state == S_RUN) ? bus.rom_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      pc              <= '0;
      bus.instr_valid <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state           <= S_RUN;
            pc              <= '0;
            bus.instr_valid <= 1'b1;
            bus.done        <= 1'b0;
          end
        end
        S_RUN: begin
          // A stall swallows any branch; the datapath re-asserts it afterwards.
          if (bus.stall) begin
            pc <= pc;
          end else if (is_halt ||
                       (bus.branch_taken && !target_ok) ||
                       (!bus.branch_taken && pc == LAST_PC)) begin
            // pc stays on the last issued word so ctr freezes there.
            state           <= S_DONE;
            bus.instr_valid <= 1'b0;
            bus.done        <= 1'b1;
          end else if (bus.branch_taken) begin
            pc <= bus.branch_target;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        default: begin
          state           <= S_IDLE;
          pc              <= '0;
          bus.instr_valid <= 1'b0;
          bus.done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state != S_RUN && bus.start) begin
      cycle_count <= '0;
    end else if (state == S_RUN && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule
